// File: rtl/p_int_acc_pkg.sv
// Shared types for the integer perceptron datapath.
// Data configuration, accumulator FSM states, width helper.
package p_int_acc_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;

  localparam dconf_t DEF_DCONF = '{
    sign: 1'b1,
    prec: 8'd8,
    frac: 8'd0
  };

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } acc_state_t;

  // Accumulator width that holds N full-scale terms.
  function automatic int acc_prec(int ip, int n);
    return ip + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/p_int_acc_if.sv
// Product-in / sum-out handshake bundle of the accumulator.
// master drives products and takes sums; slave is the accumulator.
interface p_int_acc_if #(
  parameter int I_W = 8,
  parameter int O_W = 8
);

  logic           in_valid;
  logic           in_ready;
  logic [I_W-1:0] in;
  logic           in_ovf;
  logic           out_valid;
  logic           out_ready;
  logic [O_W-1:0] out;
  logic           ovf;

  modport master (
    output in_valid, in, in_ovf, out_ready,
    input  in_ready, out_valid, out, ovf
  );

  modport slave (
    input  in_valid, in, in_ovf, out_ready,
    output in_ready, out_valid, out, ovf
  );

endinterface

// File: rtl/p_int_acc_cvt.sv
// Converts the accumulator value to the output format.
// Extends when wider, passes when equal, saturates when narrower.
module p_int_acc_cvt #(
  parameter int A_W    = 11,
  parameter bit A_SIGN = 1'b1,
  parameter int O_W    = 8,
  parameter bit O_SIGN = 1'b1
) (
  input  logic [A_W-1:0] a,
  output logic [O_W-1:0] o,
  output logic           ovf
);

  if (O_W > A_W) begin : g_exp
    localparam int EW = O_W - A_W;
    assign o   = A_SIGN ? {{EW{a[A_W-1]}}, a}
                        : {{EW{1'b0}}, a};
    assign ovf = 1'b0;
  end else if (O_W == A_W) begin : g_pass
    assign o   = a;
    assign ovf = 1'b0;
  end else begin : g_rdc
    localparam int W = A_W + 2;
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] SMAX = (ONE << (O_W - 1)) - ONE;
    localparam logic [W-1:0] UMAX = (ONE << O_W) - ONE;
    localparam logic [W-1:0] SMIN = ~SMAX;

    logic signed [W-1:0] w;
    logic signed [W-1:0] hi;
    logic signed [W-1:0] lo;

    // Compare in a wider signed domain, clip to the output range.
    always_comb begin
      w   = A_SIGN ? {{2{a[A_W-1]}}, a} : {2'b00, a};
      hi  = O_SIGN ? SMAX : UMAX;
      lo  = O_SIGN ? SMIN : '0;
      o   = a[O_W-1:0];
      ovf = 1'b0;
      if (w > hi) begin
        o   = hi[O_W-1:0];
        ovf = 1'b1;
      end else if (w < lo) begin
        o   = lo[O_W-1:0];
        ovf = 1'b1;
      end
    end
  end

endmodule

// File: rtl/p_int_acc.sv
// Dot-product accumulator: sums N products, emits one sum
// per N accepted terms with a sticky overflow flag.
module p_int_acc
  import p_int_acc_pkg::*;
#(
  parameter dconf_t I_CONF = DEF_DCONF,
  parameter dconf_t O_CONF = DEF_DCONF,
  parameter int     N      = 4
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        clr,
  p_int_acc_if.slave  bus
);

  localparam int I_PREC = int'(I_CONF.prec);
  localparam int O_PREC = int'(O_CONF.prec);
  localparam int A_PREC = acc_prec(I_PREC, N);
  localparam int EW     = A_PREC - I_PREC;
  localparam int CW     = $clog2(N + 1);
  localparam logic [CW-1:0] N_C = CW'(N);

  acc_state_t        state_q;
  logic [A_PREC-1:0] acc_q;
  logic [A_PREC-1:0] acc_d;
  logic [A_PREC-1:0] in_x;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              ovfr_q;
  logic              ovfr_d;
  logic [O_PREC-1:0] out_q;
  logic [O_PREC-1:0] cvt_out;
  logic              cvt_ovf;
  logic              ovf_q;
  logic              ovld_q;
  logic              rdy_q;
  logic              accept;
  logic              last;

  // Next accumulator value assuming this cycle's term is taken.
  always_comb begin
    in_x   = I_CONF.sign ? {{EW{bus.in[I_PREC-1]}}, bus.in}
                         : {{EW{1'b0}}, bus.in};
    accept = bus.in_valid & rdy_q;
    acc_d  = (state_q == IDLE ? '0 : acc_q) + in_x;
    cnt_d  = (state_q == IDLE ? '0 : cnt_q) + 1'b1;
    ovfr_d = ((state_q != IDLE) & ovfr_q) | bus.in_ovf;
    last   = (cnt_d == N_C);
  end

  p_int_acc_cvt #(
    .A_W    (A_PREC),
    .A_SIGN (I_CONF.sign),
    .O_W    (O_PREC),
    .O_SIGN (O_CONF.sign)
  ) u_cvt (
    .a   (acc_d),
    .o   (cvt_out),
    .ovf (cvt_ovf)
  );

  // Accumulate/emit FSM; the sum is captured on OUT entry.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovfr_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      ovld_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else if (clr) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovfr_q  <= 1'b0;
      ovld_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ovfr_q <= ovfr_d;
            if (last) begin
              state_q <= OUT;
              out_q   <= cvt_out;
              ovf_q   <= ovfr_d | cvt_ovf;
              ovld_q  <= 1'b1;
              rdy_q   <= 1'b0;
            end else begin
              state_q <= ACC;
            end
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovld_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = ovld_q;
  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_p_int_acc.sv
// Directed bench for p_int_acc: signed/unsigned configs,
// saturation, sticky overflow, backpressure, abort, reset, N=1.
module tb_p_int_acc;
  import p_int_acc_pkg::*;

  localparam dconf_t S8  = '{sign: 1'b1, prec: 8'd8,  frac: 8'd0};
  localparam dconf_t U8  = '{sign: 1'b0, prec: 8'd8,  frac: 8'd0};
  localparam dconf_t S16 = '{sign: 1'b1, prec: 8'd16, frac: 8'd0};

  logic clk = 1'b0;
  logic reset_;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  p_int_acc_if #(.I_W(8), .O_W(16)) ia ();
  p_int_acc_if #(.I_W(8), .O_W(8))  ib ();
  p_int_acc_if #(.I_W(8), .O_W(16)) ic ();

  p_int_acc #(.I_CONF(S8), .O_CONF(S16), .N(4)) u_a (
    .clk    (clk),
    .reset_ (reset_),
    .clr    (clr),
    .bus    (ia)
  );

  p_int_acc #(.I_CONF(U8), .O_CONF(U8), .N(4)) u_b (
    .clk    (clk),
    .reset_ (reset_),
    .clr    (clr),
    .bus    (ib)
  );

  p_int_acc #(.I_CONF(S8), .O_CONF(S16), .N(1)) u_c (
    .clk    (clk),
    .reset_ (reset_),
    .clr    (clr),
    .bus    (ic)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_all();
    clr = 1'b0;
    ia.in_valid = 1'b0; ia.in = '0; ia.in_ovf = 1'b0;
    ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.in = '0; ib.in_ovf = 1'b0;
    ib.out_ready = 1'b0;
    ic.in_valid = 1'b0; ic.in = '0; ic.in_ovf = 1'b0;
    ic.out_ready = 1'b0;
  endtask

  task automatic feed_a(input logic [7:0] v, input logic o);
    ia.in_valid = 1'b1; ia.in = v; ia.in_ovf = o;
    step();
    ia.in_valid = 1'b0; ia.in_ovf = 1'b0;
  endtask

  task automatic feed_b(input logic [7:0] v);
    ib.in_valid = 1'b1; ib.in = v;
    step();
    ib.in_valid = 1'b0;
  endtask

  task automatic feed_c(input logic [7:0] v);
    ic.in_valid = 1'b1; ic.in = v;
    step();
    ic.in_valid = 1'b0;
  endtask

  task automatic drain_a();
    ia.out_ready = 1'b1;
    step();
    ia.out_ready = 1'b0;
  endtask

  task automatic drain_b();
    ib.out_ready = 1'b1;
    step();
    ib.out_ready = 1'b0;
  endtask

  task automatic drain_c();
    ic.out_ready = 1'b1;
    step();
    ic.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    reset_ = 1'b0;
    step();
    step();
    total++;
    if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1 ||
        ia.out !== 16'd0 || ia.ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_a vld=%b rdy=%b out=%0d ovf=%b want 0 1 0 0",
               ia.out_valid, ia.in_ready, ia.out, ia.ovf);
    end
    total++;
    if (ib.out_valid !== 1'b0 || ib.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_b vld=%b rdy=%b want 0 1",
               ib.out_valid, ib.in_ready);
    end
    reset_ = 1'b1;
    step();
  endtask

  task automatic test_signed_dot();
    feed_a(8'd3, 1'b0);
    feed_a(8'hFB, 1'b0);
    feed_a(8'd7, 1'b0);
    total++;
    if (ia.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL early_vld got=%b want=0", ia.out_valid);
    end
    feed_a(8'd2, 1'b0);
    total++;
    if (ia.out_valid !== 1'b1 || ia.out !== 16'd7) begin
      bad++;
      $display("FAIL dot_a vld=%b out=%0d want 1 7",
               ia.out_valid, ia.out);
    end
    total++;
    if (ia.ovf !== 1'b0 || ia.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL dot_a_flags ovf=%b rdy=%b want 0 0",
               ia.ovf, ia.in_ready);
    end
  endtask

  task automatic test_backpressure();
    ia.in_valid = 1'b1;
    ia.in = 8'd9;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (ia.out_valid !== 1'b1 || ia.out !== 16'd7 ||
          ia.ovf !== 1'b0 || ia.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold%0d vld=%b out=%0d ovf=%b rdy=%b want 1 7 0 0",
                 i, ia.out_valid, ia.out, ia.ovf, ia.in_ready);
      end
    end
    ia.out_ready = 1'b1;
    ia.in = 8'd1;
    step();
    ia.out_ready = 1'b0;
    total++;
    if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release vld=%b rdy=%b want 0 1",
               ia.out_valid, ia.in_ready);
    end
    step();
    feed_a(8'd2, 1'b0);
    feed_a(8'd3, 1'b0);
    feed_a(8'd4, 1'b0);
    total++;
    if (ia.out_valid !== 1'b1 || ia.out !== 16'd10) begin
      bad++;
      $display("FAIL first_after vld=%b out=%0d want 1 10",
               ia.out_valid, ia.out);
    end
    drain_a();
  endtask

  task automatic test_sticky_ovf();
    feed_a(8'd1, 1'b0);
    feed_a(8'd1, 1'b1);
    feed_a(8'd1, 1'b0);
    feed_a(8'd1, 1'b0);
    total++;
    if (ia.out !== 16'd4 || ia.ovf !== 1'b1) begin
      bad++;
      $display("FAIL term_ovf out=%0d ovf=%b want 4 1", ia.out, ia.ovf);
    end
    drain_a();
    for (int i = 0; i < 4; i++) feed_a(8'd1, 1'b0);
    total++;
    if (ia.out !== 16'd4 || ia.ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear out=%0d ovf=%b want 4 0", ia.out, ia.ovf);
    end
    drain_a();
  endtask

  task automatic test_unsigned_sat();
    for (int i = 0; i < 4; i++) feed_b(8'd255);
    total++;
    if (ib.out_valid !== 1'b1 || ib.out !== 8'd255 ||
        ib.ovf !== 1'b1) begin
      bad++;
      $display("FAIL sat_b vld=%b out=%0d ovf=%b want 1 255 1",
               ib.out_valid, ib.out, ib.ovf);
    end
    drain_b();
    feed_b(8'd10);
    feed_b(8'd20);
    feed_b(8'd30);
    feed_b(8'd40);
    total++;
    if (ib.out !== 8'd100 || ib.ovf !== 1'b0) begin
      bad++;
      $display("FAIL sum_b out=%0d ovf=%b want 100 0", ib.out, ib.ovf);
    end
    drain_b();
  endtask

  task automatic test_abort();
    feed_a(8'd5, 1'b0);
    feed_a(8'd6, 1'b0);
    ia.in_valid = 1'b1;
    ia.in = 8'd7;
    clr = 1'b1;
    step();
    clr = 1'b0;
    ia.in_valid = 1'b0;
    step();
    step();
    total++;
    if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort vld=%b rdy=%b want 0 1",
               ia.out_valid, ia.in_ready);
    end
    feed_a(8'd1, 1'b0);
    feed_a(8'd2, 1'b0);
    feed_a(8'd3, 1'b0);
    feed_a(8'd4, 1'b0);
    total++;
    if (ia.out_valid !== 1'b1 || ia.out !== 16'd10) begin
      bad++;
      $display("FAIL after_abort vld=%b out=%0d want 1 10",
               ia.out_valid, ia.out);
    end
    drain_a();
  endtask

  task automatic test_reset_async();
    feed_a(8'd1, 1'b0);
    feed_a(8'd2, 1'b0);
    #2 reset_ = 1'b0;
    #1;
    total++;
    if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1 ||
        ia.out !== 16'd0 || ia.ovf !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid vld=%b rdy=%b out=%0d ovf=%b want 0 1 0 0",
               ia.out_valid, ia.in_ready, ia.out, ia.ovf);
    end
    step();
    reset_ = 1'b1;
    step();
    for (int i = 0; i < 4; i++) feed_a(8'd3, 1'b0);
    total++;
    if (ia.out_valid !== 1'b1 || ia.out !== 16'd12) begin
      bad++;
      $display("FAIL post_rst vld=%b out=%0d want 1 12",
               ia.out_valid, ia.out);
    end
    #2 reset_ = 1'b0;
    #1;
    total++;
    if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1 ||
        ia.out !== 16'd0) begin
      bad++;
      $display("FAIL rst_out vld=%b rdy=%b out=%0d want 0 1 0",
               ia.out_valid, ia.in_ready, ia.out);
    end
    step();
    reset_ = 1'b1;
    step();
  endtask

  task automatic test_n1();
    feed_c(8'd5);
    total++;
    if (ic.out_valid !== 1'b1 || ic.out !== 16'd5 ||
        ic.ovf !== 1'b0) begin
      bad++;
      $display("FAIL n1_pos vld=%b out=%0d ovf=%b want 1 5 0",
               ic.out_valid, ic.out, ic.ovf);
    end
    drain_c();
    feed_c(8'hFD);
    total++;
    if (ic.out_valid !== 1'b1 || ic.out !== 16'hFFFD) begin
      bad++;
      $display("FAIL n1_neg vld=%b out=%h want 1 fffd",
               ic.out_valid, ic.out);
    end
    drain_c();
    total++;
    if (ic.out_valid !== 1'b0 || ic.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL n1_drain vld=%b rdy=%b want 0 1",
               ic.out_valid, ic.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_signed_dot();
    test_backpressure();
    test_sticky_ovf();
    test_unsigned_sat();
    test_abort();
    test_reset_async();
    test_n1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
